// File: rtl/gpio_in_pkg.sv
// Shared definitions for the GPIO input block: register map, selector type
// and the pending-flag update rule used by the top level.
package gpio_in_pkg;

  localparam int unsigned GPIO_PINS = 8;

  // Register addresses, shared with the bus decoder and firmware headers.
  localparam int unsigned ADDR_IN      = 32'h00;
  localparam int unsigned ADDR_RISE_EN = 32'h01;
  localparam int unsigned ADDR_FALL_EN = 32'h02;
  localparam int unsigned ADDR_PENDING = 32'h03;
  localparam int unsigned ADDR_RAW     = 32'h04;

  typedef enum logic [2:0] {
    SEL_IN,
    SEL_RISE_EN,
    SEL_FALL_EN,
    SEL_PENDING,
    SEL_RAW,
    SEL_NONE
  } reg_sel_e;

  // Addresses are zero-extended to 32 bits so any bus width up to 32 decodes
  // exactly, with no aliasing from upper address bits.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    reg_sel_e sel;
    case (addr)
      ADDR_IN:      sel = SEL_IN;
      ADDR_RISE_EN: sel = SEL_RISE_EN;
      ADDR_FALL_EN: sel = SEL_FALL_EN;
      ADDR_PENDING: sel = SEL_PENDING;
      ADDR_RAW:     sel = SEL_RAW;
      default:      sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  // W1C with set priority: a new edge in the same cycle as a clear keeps the flag.
  function automatic logic [GPIO_PINS-1:0] pending_next(
    input logic [GPIO_PINS-1:0] cur,
    input logic [GPIO_PINS-1:0] clr,
    input logic [GPIO_PINS-1:0] set
  );
    return (cur & ~clr) | set;
  endfunction

endpackage

// File: rtl/gpio_in_debounce.sv
// One GPIO input pin: two-flop synchroniser followed by a counter-based
// debouncer that emits single-cycle rise/fall pulses as the stable value moves.
module gpio_in_debounce
  import gpio_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic CLK,
  input  logic RSTb,
  input  logic PIN,
  output logic SYNC2,
  output logic STABLE,
  output logic RISE,
  output logic FALL
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic [CNT_W-1:0] cnt;
  logic             settle;

  // The pulses are combinational so the pending register captures an edge on
  // the very clock edge that moves STABLE.
  assign settle = (SYNC2 != STABLE) && (cnt == TERMINAL);
  assign RISE   = settle &&  SYNC2;
  assign FALL   = settle && !SYNC2;

  // NOTE: non-blocking assignments make every flop here sample pre-edge values,
  // which is what turns sync1/SYNC2 into a real two-stage synchroniser.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      sync1  <= 1'b0;
      SYNC2  <= 1'b0;
      STABLE <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= PIN;
      SYNC2 <= sync1;
      if (SYNC2 == STABLE || settle) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (settle) begin
        STABLE <= SYNC2;
      end
    end
  end

endmodule

// File: rtl/gpio_in.sv
// Memory-mapped 8-pin GPIO input port with per-pin debounce, edge enables,
// a W1C pending register and a level interrupt.
module gpio_in
  import gpio_in_pkg::*;
#(
  parameter int BITS            = 16,
  parameter int ADDRESS_BITS    = 8,
  parameter int CLK_FREQ        = 12000000,
  parameter int DEBOUNCE_CYCLES = CLK_FREQ / 1000
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic [ADDRESS_BITS-1:0] ADDRESS,
  input  logic [BITS-1:0]         DATA_IN,
  output logic [BITS-1:0]         DATA_OUT,
  input  logic                    WR,
  input  logic [GPIO_PINS-1:0]    PINS_IN,
  output logic                    IRQ
);

  logic [GPIO_PINS-1:0] raw;
  logic [GPIO_PINS-1:0] stable;
  logic [GPIO_PINS-1:0] rise;
  logic [GPIO_PINS-1:0] fall;

  logic [GPIO_PINS-1:0] rise_en;
  logic [GPIO_PINS-1:0] fall_en;
  logic [GPIO_PINS-1:0] pending;

  logic [GPIO_PINS-1:0] w1c_mask;
  logic [GPIO_PINS-1:0] edge_set;
  logic [GPIO_PINS-1:0] rd_data;
  reg_sel_e             sel;

  // Only the low byte carries register data; the rest of the bus is ignored.
  logic unused_data_in;
  assign unused_data_in = ^DATA_IN;

  for (genvar p = 0; p < GPIO_PINS; p++) begin : g_pin
    gpio_in_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .CLK   (CLK),
      .RSTb  (RSTb),
      .PIN   (PINS_IN[p]),
      .SYNC2 (raw[p]),
      .STABLE(stable[p]),
      .RISE  (rise[p]),
      .FALL  (fall[p])
    );
  end

  assign sel      = decode_addr(32'(ADDRESS));
  assign w1c_mask = (WR && sel == SEL_PENDING) ? DATA_IN[GPIO_PINS-1:0] : '0;
  // Enables are the registered values, so a write lands for edges from the next cycle.
  assign edge_set = (rise & rise_en) | (fall & fall_en);

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      rise_en <= '0;
      fall_en <= '0;
      pending <= '0;
    end else begin
      if (WR && sel == SEL_RISE_EN) begin
        rise_en <= DATA_IN[GPIO_PINS-1:0];
      end
      if (WR && sel == SEL_FALL_EN) begin
        fall_en <= DATA_IN[GPIO_PINS-1:0];
      end
      pending <= pending_next(pending, w1c_mask, edge_set);
    end
  end

  // NOTE: rd_data gets a default before the case so no latch is inferred
  // for unmapped addresses.
  always_comb begin
    rd_data = '0;
    case (sel)
      SEL_IN:      rd_data = stable;
      SEL_RISE_EN: rd_data = rise_en;
      SEL_FALL_EN: rd_data = fall_en;
      SEL_PENDING: rd_data = pending;
      SEL_RAW:     rd_data = raw;
      default:     rd_data = '0;
    endcase
  end

  assign DATA_OUT = BITS'(rd_data);
  assign IRQ      = |pending;

endmodule

// File: tb/tb_gpio_in.sv
// Self-checking bench for gpio_in: directed scenarios plus randomized traffic,
// compared against a sample-history reference model.
module tb_gpio_in;

  localparam int D = 4;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic [7:0]  ADDRESS = '0;
  logic [15:0] DATA_IN = '0;
  logic [15:0] DATA_OUT;
  logic        WR = 1'b0;
  logic [7:0]  PINS_IN = '0;
  logic        IRQ;

  int checks = 0;
  int failures = 0;

  // hist[0] is the most recent sampled pin vector, hist[D] the oldest kept.
  logic [7:0] hist [0:D];
  logic [7:0] m_stable = '0;
  logic [7:0] m_rise_en = '0;
  logic [7:0] m_fall_en = '0;
  logic [7:0] m_pending = '0;

  gpio_in #(
    .BITS(16),
    .ADDRESS_BITS(8),
    .CLK_FREQ(12000000),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLK(CLK),
    .RSTb(RSTb),
    .ADDRESS(ADDRESS),
    .DATA_IN(DATA_IN),
    .DATA_OUT(DATA_OUT),
    .WR(WR),
    .PINS_IN(PINS_IN),
    .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  // The stable value of a pin follows the synchronised pin once that value
  // has been seen, different from the stable value, for D consecutive cycles.
  task automatic model_step();
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] clr;
    logic       same;
    if (!RSTb) begin
      for (int k = 0; k <= D; k++) hist[k] = '0;
      m_stable  = '0;
      m_rise_en = '0;
      m_fall_en = '0;
      m_pending = '0;
    end else begin
      rise = '0;
      fall = '0;
      for (int p = 0; p < 8; p++) begin
        same = 1'b1;
        for (int k = 2; k <= D; k++) if (hist[k][p] != hist[1][p]) same = 1'b0;
        if (same && hist[1][p] != m_stable[p]) begin
          if (hist[1][p]) rise[p] = 1'b1;
          else            fall[p] = 1'b1;
        end
      end
      m_stable = m_stable ^ (rise | fall);
      clr = (WR && ADDRESS == 8'h03) ? DATA_IN[7:0] : 8'h00;
      m_pending = (m_pending & ~clr) | (rise & m_rise_en) | (fall & m_fall_en);
      if (WR && ADDRESS == 8'h01) m_rise_en = DATA_IN[7:0];
      if (WR && ADDRESS == 8'h02) m_fall_en = DATA_IN[7:0];
      for (int k = D; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = PINS_IN;
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [7:0] addr);
    logic [7:0] v;
    case (addr)
      8'h00:   v = m_stable;
      8'h01:   v = m_rise_en;
      8'h02:   v = m_fall_en;
      8'h03:   v = m_pending;
      8'h04:   v = hist[1];
      default: v = 8'h00;
    endcase
    return {8'h00, v};
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [7:0] addr, input logic [15:0] data);
    ADDRESS = addr;
    DATA_IN = data;
    WR = 1'b1;
    tick();
    WR = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [15:0] exp);
    ADDRESS = addr;
    #1;
    check(tag, DATA_OUT, exp);
  endtask

  task automatic check_model(input string tag);
    for (int a = 0; a < 6; a++) begin
      ADDRESS = 8'(a);
      #1;
      check(tag, DATA_OUT, exp_read(8'(a)));
    end
    ADDRESS = 8'hFF;
    #1;
    check(tag, DATA_OUT, 16'h0000);
    check(tag, {15'b0, IRQ}, {15'b0, |m_pending});
  endtask

  initial begin
    for (int k = 0; k <= D; k++) hist[k] = '0;

    // Reset, then every address reads zero.
    RSTb = 1'b0;
    ticks(2);
    RSTb = 1'b1;
    for (int a = 0; a < 6; a++) rd("reset_read", 8'(a), 16'h0000);
    check("reset_irq", {15'b0, IRQ}, 16'h0000);
    check_model("reset_model");

    // Rising edge on pin 0 with RISE_EN set.
    wr(8'h01, 16'hFF01);
    rd("rise_en_upper_zero", 8'h01, 16'h0001);
    PINS_IN[0] = 1'b1;
    ticks(2);
    rd("raw_after_2", 8'h04, 16'h0001);
    ticks(3);
    rd("in_after_5", 8'h00, 16'h0000);
    rd("pend_after_5", 8'h03, 16'h0000);
    tick();
    rd("in_after_6", 8'h00, 16'h0001);
    rd("pend_after_6", 8'h03, 16'h0001);
    check("irq_after_6", {15'b0, IRQ}, 16'h0001);
    check_model("pin0_model");

    // Writes to read-only and unmapped addresses are ignored.
    wr(8'h00, 16'h00FF);
    wr(8'h04, 16'h00FF);
    wr(8'h10, 16'h00FF);
    rd("ro_in", 8'h00, 16'h0001);
    rd("unmapped", 8'h10, 16'h0000);
    wr(8'h03, 16'h00FF);
    rd("w1c_all", 8'h03, 16'h0000);
    check_model("ro_model");

    // Bounce on pin 3: high 3, low 1, then held high.
    PINS_IN[3] = 1'b1;
    ticks(3);
    PINS_IN[3] = 1'b0;
    tick();
    PINS_IN[3] = 1'b1;
    ticks(5);
    rd("bounce_after_5", 8'h00, 16'h0001);
    tick();
    rd("bounce_after_6", 8'h00, 16'h0009);
    check_model("bounce_model");

    // Pin 7 with only FALL_EN: flag only after the fall.
    wr(8'h02, 16'h0080);
    wr(8'h01, 16'h0000);
    PINS_IN[7] = 1'b1;
    ticks(6);
    rd("p7_rise_in", 8'h00, 16'h0089);
    rd("p7_rise_pend", 8'h03, 16'h0000);
    PINS_IN[7] = 1'b0;
    ticks(5);
    rd("p7_fall_pend_5", 8'h03, 16'h0000);
    tick();
    rd("p7_fall_pend_6", 8'h03, 16'h0080);
    check("p7_irq", {15'b0, IRQ}, 16'h0001);

    // Build PENDING=0x81 then clear bit by bit.
    wr(8'h01, 16'h0001);
    PINS_IN[0] = 1'b0;
    ticks(6);
    PINS_IN[0] = 1'b1;
    ticks(6);
    rd("pend_81", 8'h03, 16'h0081);
    wr(8'h03, 16'h0001);
    rd("w1c_bit0", 8'h03, 16'h0080);
    check("w1c_bit0_irq", {15'b0, IRQ}, 16'h0001);
    wr(8'h03, 16'h0080);
    rd("w1c_bit7", 8'h03, 16'h0000);
    check("w1c_bit7_irq", {15'b0, IRQ}, 16'h0000);
    check_model("w1c_model");

    // W1C on the same edge as a new enabled edge on pin 2: set wins.
    wr(8'h01, 16'h0005);
    PINS_IN[2] = 1'b1;
    ticks(5);
    rd("coll_before", 8'h03, 16'h0000);
    wr(8'h03, 16'h0004);
    rd("coll_set_wins", 8'h03, 16'h0004);
    check("coll_irq", {15'b0, IRQ}, 16'h0001);

    // Reset mid-debounce of pin 5.
    PINS_IN[5] = 1'b1;
    ticks(3);
    RSTb = 1'b0;
    tick();
    RSTb = 1'b1;
    rd("rst_pend_lost", 8'h03, 16'h0000);
    check("rst_irq", {15'b0, IRQ}, 16'h0000);
    ticks(5);
    rd("rst_in_after_5", 8'h00, 16'h0000);
    tick();
    rd("rst_in_after_6", 8'h00, 16'h002D);
    check_model("rst_model");

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 8; p++) begin
        if ($urandom_range(0, 9) == 0) PINS_IN[p] = ~PINS_IN[p];
      end
      WR      = ($urandom_range(0, 5) == 0);
      ADDRESS = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      DATA_IN = 16'($urandom);
      RSTb    = ($urandom_range(0, 499) != 0);
      tick();
      WR   = 1'b0;
      RSTb = 1'b1;
      ADDRESS = 8'($urandom_range(0, 5));
      #1;
      check("rnd_read", DATA_OUT, exp_read(ADDRESS));
      check("rnd_irq", {15'b0, IRQ}, {15'b0, |m_pending});
    end
    check_model("final_model");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_in.md
# gpio_in

Memory-mapped GPIO input port: synchronises 8 external input pins, debounces each pin independently, and latches rising/falling edges into a write-one-to-clear pending register that drives an interrupt line. Sits beside the GPIO output register on the same peripheral bus slot pattern (ADDRESS/DATA_IN/DATA_OUT/WR). It supplies the read data and interrupt that the output-only GPIO block does not provide.

## Interface

- BITS, 16, bus data width; registers occupy bits [7:0], upper bits read 0.
- ADDRESS_BITS, 8, bus address width.
- CLK_FREQ, 12000000, system clock in Hz; informational, used only to derive the DEBOUNCE_CYCLES default.
- DEBOUNCE_CYCLES, CLK_FREQ/1000, cycles a synchronised pin must differ from its stable value before the stable value changes; legal range ≥1.

Ports:

- CLK  in  1  system clock; all logic on rising edge.
- RSTb  in  1  synchronous, active-low reset.
- ADDRESS  in  ADDRESS_BITS  register select.
- DATA_IN  in  BITS  write data.
- DATA_OUT  out  BITS  read data; combinational from ADDRESS and registers.
- WR  in  1  write strobe; one write per cycle high.
- PINS_IN  in  8  asynchronous external inputs.
- IRQ  out  1  high while any PENDING bit is set.

## Operation

- Register map, 8-bit fields:
  - 0x00 IN: debounced stable state. Read-only.
  - 0x01 RISE_EN: per-pin rising-edge enable. Read/write.
  - 0x02 FALL_EN: per-pin falling-edge enable. Read/write.
  - 0x03 PENDING: per-pin edge flags. A read returns the flags; writing a 1 clears that bit (W1C).
  - 0x04 RAW: synchroniser output. Read-only.
  - Any other address reads 0; writes to it are ignored. Writes to read-only addresses are ignored.
- Synchroniser: two flops per pin, sync1 then sync2. Reset value 0.
- Debounce, per pin, with a counter of width clog2(DEBOUNCE_CYCLES)+1:
  - If sync2 == stable, the counter resets to 0.
  - If sync2 != stable and counter == DEBOUNCE_CYCLES-1, stable becomes sync2 and the counter resets to 0.
  - Otherwise the counter increments.
  - Any bounce back to the stable value before terminal count restarts the count from 0.
- Edge detection happens in the same cycle stable updates:
  - 0→1 transition with RISE_EN set, or 1→0 transition with FALL_EN set, sets the PENDING bit.
  - Edges on pins whose enable is clear are discarded. Enabling later does not recover them.
- Simultaneous W1C and a new edge on the same bit: the set wins, so PENDING stays 1.
- Writes to RISE_EN/FALL_EN take effect for edges evaluated on the following cycle onward.
- IRQ = |PENDING, combinational from registers, so it is glitch-free.
- Reset values: all registers, counters and synchronisers are 0; DATA_OUT reads 0 at address 0x00; IRQ is 0. Pins already high at reset produce a rising edge after debounce only if RISE_EN has been set by then.
- Reset mid-debounce: counters and stable return to 0 and any pending flags are lost.

## Timing

- PINS_IN settles before edge 0:
  - sync1 at edge 1, sync2 at edge 2.
  - stable and PENDING update at edge 2+DEBOUNCE_CYCLES.
  - IRQ rises in the same cycle PENDING updates.
- Write latency: a register write with WR high at edge k is visible on DATA_OUT after edge k.
- W1C clears the PENDING bit at the write edge; IRQ falls in the next cycle if no other bit is set.
- Read latency: zero cycles (combinational mux). No read side effects.

## Structure

- A shared header holds localparams for register addresses 0x00–0x04, for reuse by the bus decoder and firmware headers.
- Sub-module gpio_in_debounce: one pin, parameter DEBOUNCE_CYCLES, inputs CLK/RSTb/raw pin. It outputs sync2 and stable, plus one-cycle rise/fall pulses.
- Top level: instantiates 8 of gpio_in_debounce and holds the enable and pending registers plus the read mux.

## Test plan

Run the bench with DEBOUNCE_CYCLES=4.

- Reset then read all addresses: every value is 0 and IRQ is 0.
- Write RISE_EN=0x01, drive PINS_IN[0] 0→1 and hold: RAW bit 0 is 1 after 2 edges; IN=0x01, PENDING=0x01 and IRQ=1 exactly 6 edges after the pin change.
- Bounce PINS_IN[3]: high 3 cycles, low 1, high 4+: IN[3] updates only 6 edges after the final rise.
- With FALL_EN=0x80 and RISE_EN=0, toggle pin 7 0→1→0 with debounce each way: PENDING is 0x80 only after the fall, never after the rise.
- PENDING=0x81; write 0x01 to 0x03: PENDING=0x80 and IRQ stays 1. Write 0x80: IRQ goes 0 the next cycle.
- Time a W1C of bit 2 on the same edge as a new enabled edge on pin 2: PENDING[2] remains 1.
- Assert RSTb=0 for 1 cycle mid-debounce of pin 5: the counter restarts and IN[5] changes only 6 edges after reset is released.
